tail_mode_input: RTL and testbench

Input-side front end for the tail-lights controller. It samples the raw 3-bit mode switches, synchronises and debounces them as one vector, and presents each new stable mode code to the light/display logic through a req/ack handshake. It sits between the board switch pins and the mode-select logic that drives the LED patterns and seven-segment display.

---
 rtl/tail_lights_pkg.sv | 30 +++
 rtl/tail_mode_input_if.sv | 33 +++
 rtl/tail_mode_input_sync_2ff.sv | 41 ++++
 rtl/tail_mode_input.sv | 150 +++++++++++++++
 tb/tb_tail_mode_input.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tail_lights_pkg.sv
// ----------------------------------------------------------------------------
// tail_lights_pkg
// Shared definitions for the tail-lights controller:
//   - mode_t            : 3-bit mode code carried from the switches
//   - MODE_* constants  : the legal mode codes (1..5) plus MODE_OFF
//   - hs_state_e        : state encoding of the mode req/ack handshake
//   - is_legal_mode()   : 1 when a code is one of MODE_HAZARD..MODE_FLASH
// ----------------------------------------------------------------------------
package tail_lights_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_OFF    = 3'd0;
   localparam mode_t MODE_HAZARD = 3'd1;
   localparam mode_t MODE_LEFT   = 3'd2;
   localparam mode_t MODE_RIGHT  = 3'd3;
   localparam mode_t MODE_BRAKE  = 3'd4;
   localparam mode_t MODE_FLASH  = 3'd5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } hs_state_e;

   // Codes 0, 6 and 7 are still delivered downstream, just flagged illegal.
   function automatic logic is_legal_mode(input mode_t code);
      return (code >= MODE_HAZARD) && (code <= MODE_FLASH);
   endfunction

endpackage

// File: rtl/tail_mode_input_if.sv
// ----------------------------------------------------------------------------
// tail_mode_input_if
// Mode hand-off bus between the switch front end and the mode-select logic.
//   mode       : last accepted stable mode code
//   mode_legal : mode is in 1..5
//   mode_req   : a new mode is pending
//   mode_ack   : consumer accepts the pending mode
//   glitch_cnt : saturating count of rejected bounce events
// master = tail_mode_input (producer), slave = consumer.
// ----------------------------------------------------------------------------
interface tail_mode_input_if
   import tail_lights_pkg::*;
#(
   parameter int GLITCH_W = 8
);

   mode_t               mode;
   logic                mode_legal;
   logic                mode_req;
   logic                mode_ack;
   logic [GLITCH_W-1:0] glitch_cnt;

   modport master (
      output mode, mode_legal, mode_req, glitch_cnt,
      input  mode_ack
   );

   modport slave (
      input  mode, mode_legal, mode_req, glitch_cnt,
      output mode_ack
   );

endinterface

// File: rtl/tail_mode_input_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a vector of asynchronous inputs. Each bit is
// synchronised independently; bits of a vector may therefore land on
// different cycles, which the downstream debounce tolerates.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_i    : asynchronous input vector
//   sync_o     : vector delayed by two clk edges, safe to use in clk domain
// ----------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/tail_mode_input.sv
// ----------------------------------------------------------------------------
// tail_mode_input
// Switch front end for the tail-lights controller. Synchronises the raw 3-bit
// mode switches, debounces them as one vector, counts rejected bounces and
// offers each newly accepted code to the mode-select logic over req/ack.
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset
//   sw_raw     : raw switch pins, asynchronous to clk
//   bus        : master side of tail_mode_input_if
//                (mode, mode_legal, mode_req, glitch_cnt out; mode_ack in)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive unchanged cycles needed to accept a code (>=1)
//   GLITCH_W        : width of the saturating glitch counter
// ----------------------------------------------------------------------------
module tail_mode_input
   import tail_lights_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int GLITCH_W        = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  mode_t              sw_raw,
   tail_mode_input_if.master  bus
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // -------------------------------------------------------------------------
   // Synchroniser
   // -------------------------------------------------------------------------
   mode_t sw_sync;

   sync_2ff #(
      .WIDTH (3)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (sw_raw),
      .sync_o  (sw_sync)
   );

   // -------------------------------------------------------------------------
   // Debounce and glitch counting
   // -------------------------------------------------------------------------
   mode_t               sw_prev_q, sw_prev_d;
   mode_t               stable_q,  stable_d;
   logic [CNT_W-1:0]    db_cnt_q,  db_cnt_d;
   logic                upd_q,     upd_d;
   logic [GLITCH_W-1:0] glitch_q,  glitch_d;

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      sw_prev_d = sw_sync;
      stable_d  = stable_q;
      db_cnt_d  = db_cnt_q;
      upd_d     = 1'b0;
      glitch_d  = glitch_q;

      if (sw_sync != sw_prev_q) begin
         // Any movement restarts the count; the whole vector must then hold
         // still, so intermediate codes from staggered bits never qualify.
         db_cnt_d = '0;
         // A change that interrupts a count in progress is a rejected bounce.
         if ((db_cnt_q != '0) && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
         end
      end else if (sw_sync != stable_q) begin
         if (db_cnt_q == CNT_LAST) begin
            stable_d = sw_sync;
            db_cnt_d = '0;
            upd_d    = 1'b1;
         end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_prev_q <= MODE_OFF;
         stable_q  <= MODE_OFF;
         db_cnt_q  <= '0;
         upd_q     <= 1'b0;
         glitch_q  <= '0;
      end else begin
         sw_prev_q <= sw_prev_d;
         stable_q  <= stable_d;
         db_cnt_q  <= db_cnt_d;
         upd_q     <= upd_d;
         glitch_q  <= glitch_d;
      end
   end

   // -------------------------------------------------------------------------
   // Handshake FSM
   // -------------------------------------------------------------------------
   hs_state_e state_q, state_d;
   mode_t     mode_q,  mode_d;
   logic      legal_q, legal_d;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      legal_d = legal_q;

      case (state_q)
         ST_IDLE: begin
            // A stray ack with nothing pending is ignored.
            if (upd_q) begin
               mode_d  = stable_q;
               legal_d = is_legal_mode(stable_q);
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // A fresh code supersedes the pending one even if it is being
            // acked on this edge; the request stays up for the new code.
            if (upd_q) begin
               mode_d  = stable_q;
               legal_d = is_legal_mode(stable_q);
            end else if (bus.mode_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_OFF;
         legal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         legal_q <= legal_d;
      end
   end

   assign bus.mode       = mode_q;
   assign bus.mode_legal = legal_q;
   assign bus.mode_req   = (state_q == ST_REQ);
   assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_tail_mode_input.sv
// ----------------------------------------------------------------------------
// tb_tail_mode_input
// Self-checking bench for tail_mode_input with DEBOUNCE_CYCLES = 4.
// A behavioural model tracks how long the synchronised switch vector has held
// its value and derives accepted codes, glitches and the req/ack state from
// that; every cycle the DUT outputs are compared against it. Scenario tasks
// add targeted checks on latency, supersession, reset and saturation.
// ----------------------------------------------------------------------------
module tb_tail_mode_input;
   import tail_lights_pkg::*;

   localparam int DC   = 4;
   localparam int GW   = 8;
   localparam int GMAX = (1 << GW) - 1;

   logic  clk    = 1'b0;
   logic  rst_n  = 1'b1;
   mode_t sw_raw = 3'd0;

   tail_mode_input_if #(.GLITCH_W(GW)) bus ();

   tail_mode_input #(
      .DEBOUNCE_CYCLES (DC),
      .GLITCH_W        (GW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (sw_raw),
      .bus    (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   // -------------------------------------------------------------------------
   // Reference model
   // The switch value seen by the debounce is sw_raw two edges late. A code is
   // accepted once that delayed value has been observed unchanged for DC+1
   // consecutive samples while differing from the accepted code. A change that
   // ends a run of at least two samples of a not-yet-accepted code is a glitch.
   // The accepted code is offered downstream one edge after acceptance.
   // -------------------------------------------------------------------------
   mode_t m_dly[2];
   mode_t m_last;
   int    m_run;
   mode_t m_stable;
   bit    m_upd;
   mode_t m_mode;
   bit    m_legal;
   bit    m_req;
   int    m_glitch;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_dly[0] = 3'd0;
         m_dly[1] = 3'd0;
         m_last   = 3'd0;
         m_run    = 1;
         m_stable = 3'd0;
         m_upd    = 1'b0;
         m_mode   = 3'd0;
         m_legal  = 1'b0;
         m_req    = 1'b0;
         m_glitch = 0;
      end else begin
         mode_t cur;
         bit    accept;
         // hand-off: driven by the acceptance of the previous edge
         if (m_upd) begin
            m_mode  = m_stable;
            m_legal = (m_stable >= 3'd1) && (m_stable <= 3'd5);
            m_req   = 1'b1;
         end else if (m_req && bus.mode_ack) begin
            m_req = 1'b0;
         end
         // debounce on the current delayed sample
         cur    = m_dly[1];
         accept = 1'b0;
         if (cur != m_last) begin
            if ((m_last != m_stable) && (m_run >= 2) && (m_glitch < GMAX))
               m_glitch = m_glitch + 1;
            m_run = 1;
         end else begin
            m_run = m_run + 1;
         end
         if ((cur != m_stable) && (m_run == DC + 1)) begin
            m_stable = cur;
            accept   = 1'b1;
         end
         m_upd    = accept;
         m_last   = cur;
         m_dly[1] = m_dly[0];
         m_dly[0] = sw_raw;
      end
   end

   // Advance one cycle; sample just after the falling edge, far from posedge.
   task automatic tick();
      @(negedge clk);
      #1;
      if (chk_on) begin
         n_checks++;
         if (bus.mode !== m_mode || bus.mode_legal !== m_legal ||
             bus.mode_req !== m_req || bus.glitch_cnt !== GW'(m_glitch)) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t got mode=%0d legal=%0b req=%0b glitch=%0d want mode=%0d legal=%0b req=%0b glitch=%0d",
                     $time, bus.mode, bus.mode_legal, bus.mode_req, bus.glitch_cnt,
                     m_mode, m_legal, m_req, m_glitch);
         end
      end
   endtask

   // Request collector: records every code the DUT presents (new request or
   // superseding code), optionally acking each one.
   mode_t col_codes[$];
   bit    col_legal[$];
   bit    col_was;
   mode_t col_last;

   task automatic collect_clear();
      col_codes.delete();
      col_legal.delete();
      col_was  = 1'b0;
      col_last = 3'd0;
   endtask

   task automatic collect(input int n, input bit auto_ack);
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.mode_req && (!col_was || bus.mode != col_last)) begin
            col_codes.push_back(bus.mode);
            col_legal.push_back(bus.mode_legal);
         end
         col_was      = bus.mode_req;
         col_last     = bus.mode;
         bus.mode_ack = auto_ack && bus.mode_req;
      end
      bus.mode_ack = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      bus.mode_ack = 1'b0;
      sw_raw       = 3'd2;
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.mode !== 3'd0 || bus.mode_legal !== 1'b0 || bus.mode_req !== 1'b0 ||
          bus.glitch_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_values got mode=%0d legal=%0b req=%0b glitch=%0d want all 0",
                  bus.mode, bus.mode_legal, bus.mode_req, bus.glitch_cnt);
      end
      chk_on = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_first_request();
      int found;
      found = -1;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.mode_req && found < 0) found = k;
      end
      n_checks++;
      if (found != 7) begin
         n_fail++;
         $display("FAIL first_req_edge got %0d want 7", found);
      end
      n_checks++;
      if (bus.mode !== 3'd2 || bus.mode_legal !== 1'b1) begin
         n_fail++;
         $display("FAIL first_req_code got mode=%0d legal=%0b want mode=2 legal=1",
                  bus.mode, bus.mode_legal);
      end
      bus.mode_ack = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
      n_checks++;
      if (bus.mode_req !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_clears_req got %0b want 0", bus.mode_req);
      end
   endtask

   task automatic test_bounce();
      collect_clear();
      for (int i = 0; i < 10; i++) begin
         sw_raw = (i % 2 == 0) ? 3'd3 : 3'd1;
         collect(2, 1'b1);
      end
      sw_raw = 3'd1;
      collect(15, 1'b1);
      n_checks++;
      if (col_codes.size() != 1) begin
         n_fail++;
         $display("FAIL bounce_req_count got %0d want 1", col_codes.size());
      end else begin
         n_checks++;
         if (col_codes[0] !== 3'd1) begin
            n_fail++;
            $display("FAIL bounce_code got %0d want 1", col_codes[0]);
         end
      end
      n_checks++;
      if (!(bus.glitch_cnt > 0)) begin
         n_fail++;
         $display("FAIL bounce_glitch got %0d want >0", bus.glitch_cnt);
      end
   endtask

   task automatic test_staggered_bits();
      collect_clear();
      sw_raw = 3'd0;
      collect(14, 1'b1);
      collect_clear();
      sw_raw = 3'd4; collect(1, 1'b1);
      sw_raw = 3'd6; collect(1, 1'b1);
      sw_raw = 3'd7; collect(16, 1'b1);
      n_checks++;
      if (col_codes.size() != 1) begin
         n_fail++;
         $display("FAIL stagger_req_count got %0d want 1", col_codes.size());
      end else begin
         n_checks++;
         if (col_codes[0] !== 3'd7 || col_legal[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stagger_code got mode=%0d legal=%0b want mode=7 legal=0",
                     col_codes[0], col_legal[0]);
         end
      end
   endtask

   task automatic test_supersede();
      int  waited;
      bit  dropped;
      sw_raw = 3'd2;
      waited = 0;
      while (!bus.mode_req && waited < 20) begin
         tick();
         waited++;
      end
      n_checks++;
      if (!bus.mode_req || bus.mode !== 3'd2) begin
         n_fail++;
         $display("FAIL supersede_first got req=%0b mode=%0d want req=1 mode=2",
                  bus.mode_req, bus.mode);
      end
      sw_raw  = 3'd5;
      dropped = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.mode_req !== 1'b1) dropped = 1'b1;
      end
      n_checks++;
      if (dropped) begin
         n_fail++;
         $display("FAIL supersede_req_held got dropped=1 want dropped=0");
      end
      n_checks++;
      if (bus.mode !== 3'd5 || bus.mode_legal !== 1'b1) begin
         n_fail++;
         $display("FAIL supersede_code got mode=%0d legal=%0b want mode=5 legal=1",
                  bus.mode, bus.mode_legal);
      end
      // ack lands on the same edge as the next update
      sw_raw = 3'd6;
      waited = 0;
      while (!m_upd && waited < 20) begin
         tick();
         waited++;
      end
      n_checks++;
      if (!m_upd) begin
         n_fail++;
         $display("FAIL supersede_upd_timeout got waited=%0d want upd within 20", waited);
      end
      bus.mode_ack = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
      n_checks++;
      if (bus.mode_req !== 1'b1 || bus.mode !== 3'd6 || bus.mode_legal !== 1'b0) begin
         n_fail++;
         $display("FAIL upd_with_ack got req=%0b mode=%0d legal=%0b want req=1 mode=6 legal=0",
                  bus.mode_req, bus.mode, bus.mode_legal);
      end
      bus.mode_ack = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
      n_checks++;
      if (bus.mode_req !== 1'b0) begin
         n_fail++;
         $display("FAIL supersede_final_ack got req=%0b want 0", bus.mode_req);
      end
   endtask

   task automatic test_reset_mid_debounce();
      int found;
      sw_raw = 3'd3;
      // two edges to reach the synchroniser output, one to register the
      // change, two more counts: the debounce count now stands at 2
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.mode !== 3'd0 || bus.mode_legal !== 1'b0 || bus.mode_req !== 1'b0 ||
          bus.glitch_cnt !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_values got mode=%0d legal=%0b req=%0b glitch=%0d want all 0",
                  bus.mode, bus.mode_legal, bus.mode_req, bus.glitch_cnt);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      found = -1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.mode_req && found < 0) found = k;
      end
      n_checks++;
      if (found != 7 || bus.mode !== 3'd3) begin
         n_fail++;
         $display("FAIL mid_reset_req got edge=%0d mode=%0d want edge=7 mode=3", found, bus.mode);
      end
      bus.mode_ack = 1'b1;
      tick();
      bus.mode_ack = 1'b0;
   endtask

   task automatic test_glitch_saturation();
      for (int i = 0; i < 300; i++) begin
         sw_raw = (i % 2 == 0) ? 3'd1 : 3'd2;
         repeat (2) tick();
      end
      sw_raw = 3'd3;
      repeat (6) tick();
      n_checks++;
      if (bus.glitch_cnt !== GW'(GMAX)) begin
         n_fail++;
         $display("FAIL glitch_saturate got %0d want %0d", bus.glitch_cnt, GMAX);
      end
      n_checks++;
      if (bus.mode_req !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_no_req got %0b want 0", bus.mode_req);
      end
   endtask

   task automatic test_random();
      int cycles;
      cycles = 0;
      while (cycles < 600) begin
         int hold;
         sw_raw = mode_t'($urandom_range(0, 7));
         hold   = int'($urandom_range(1, 9));
         for (int i = 0; i < hold; i++) begin
            bus.mode_ack = ($urandom_range(0, 3) == 0);
            tick();
            cycles++;
         end
      end
      bus.mode_ack = 1'b0;
      repeat (12) tick();
   endtask

   initial begin
      test_reset();
      test_first_request();
      test_bounce();
      test_staggered_bits();
      test_supersede();
      test_reset_mid_debounce();
      test_glitch_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish by %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
